// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration bitstream loader.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CRC   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } cfg_state_t;

    localparam logic [7:0] CFG_CMD_LOAD = 8'hA5;
    localparam logic [7:0] CFG_CRC_POLY = 8'h07;

    // One bit-serial CRC-8 step, MSB-first.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_serial_sync.sv
// Synchronizes the serial link into clk and produces registered edge strobes.
module cfg_serial_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    localparam int unsigned TOP = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_last;
    logic                   cs_last;

    // Synchronizers keep tracking through reset so no false edge appears on release.
    always_ff @(posedge clk) begin
        sck_q    <= {sck_q[SYNC_STAGES-2:0], spi_sck};
        cs_q     <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_q   <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
        sck_last <= sck_q[TOP];
        cs_last  <= cs_q[TOP];
        mosi_s   <= mosi_q[TOP];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_rise <= 1'b0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
        end else begin
            sck_rise <= sck_q[TOP] & ~sck_last;
            cs_fall  <= cs_last & ~cs_q[TOP];
            cs_rise  <= ~cs_last & cs_q[TOP];
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Serial bitstream loader: command check, payload shift into the config chain, CRC-8 verify.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CFG_BITS    = 1024,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic cfg_data,
    output logic cfg_shift_en,
    output logic cfg_done,
    output logic cfg_error,
    output logic fabric_rst,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(CFG_BITS + 1);

    logic sck_rise;
    logic cs_fall;
    logic cs_rise;
    logic mosi_s;

    cfg_serial_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .sck_rise (sck_rise),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s)
    );

    cfg_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bcnt, bcnt_n;
    logic [7:0]       sr, sr_n;
    logic [7:0]       crc, crc_n;
    logic [7:0]       sr_shift;
    logic             data_n, shift_n, done_n, error_n, frst_n, busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bcnt         <= '0;
            sr           <= '0;
            crc          <= '0;
            cfg_data     <= 1'b0;
            cfg_shift_en <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            fabric_rst   <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bcnt         <= bcnt_n;
            sr           <= sr_n;
            crc          <= crc_n;
            cfg_data     <= data_n;
            cfg_shift_en <= shift_n;
            cfg_done     <= done_n;
            cfg_error    <= error_n;
            fabric_rst   <= frst_n;
            busy         <= busy_n;
        end
    end

    // Next-state logic; a cs rise mid-frame takes priority over a coincident sck rise.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bcnt_n   = bcnt;
        sr_n     = sr;
        crc_n    = crc;
        data_n   = cfg_data;
        shift_n  = 1'b0;
        sr_shift = {sr[6:0], mosi_s};

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cs_fall) begin
                    state_n = ST_CMD;
                    cnt_n   = '0;
                    bcnt_n  = '0;
                    sr_n    = '0;
                    crc_n   = '0;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_n = ST_ERROR;
                end else if (sck_rise) begin
                    sr_n   = sr_shift;
                    bcnt_n = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_n = (sr_shift == CFG_CMD_LOAD) ? ST_LOAD : ST_ERROR;
                    end
                end
            end
            ST_LOAD: begin
                if (cs_rise) begin
                    state_n = ST_ERROR;
                end else if (sck_rise) begin
                    data_n  = mosi_s;
                    shift_n = 1'b1;
                    crc_n   = crc8_next(crc, mosi_s);
                    cnt_n   = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(CFG_BITS - 1)) begin
                        state_n = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (cs_rise) begin
                    state_n = ST_ERROR;
                end else if (sck_rise) begin
                    sr_n   = sr_shift;
                    bcnt_n = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_n = (sr_shift == crc) ? ST_DONE : ST_ERROR;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        done_n  = (state_n == ST_DONE);
        error_n = (state_n == ST_ERROR);
        frst_n  = (state_n != ST_DONE);
        busy_n  = (state_n == ST_CMD) || (state_n == ST_LOAD) || (state_n == ST_CRC);
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with a scoreboard of expected config-chain bits.
module tb_fpga_cfg_loader;

    localparam int unsigned CFG_BITS    = 16;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF        = 4;

    logic clk = 1'b0;
    logic rst;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic cfg_data;
    logic cfg_shift_en;
    logic cfg_done;
    logic cfg_error;
    logic fabric_rst;
    logic busy;

    int total   = 0;
    int bad     = 0;
    int nstrobe = 0;
    logic exp_q[$];

    fpga_cfg_loader #(
        .CFG_BITS    (CFG_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .cfg_data     (cfg_data),
        .cfg_shift_en (cfg_shift_en),
        .cfg_done     (cfg_done),
        .cfg_error    (cfg_error),
        .fabric_rst   (fabric_rst),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest expected payload bit.
    always @(negedge clk) begin
        if (cfg_shift_en === 1'b1) begin
            nstrobe++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL strobe_unexpected: observed strobe data=%0b expected no strobe", cfg_data);
            end else begin
                logic e;
                e = exp_q.pop_front();
                assert (cfg_data === e) else begin
                    bad++;
                    $error("FAIL cfg_data: observed=%0b expected=%0b", cfg_data, e);
                end
            end
        end
    end

    function automatic logic [7:0] crc_model(input logic [15:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ p[i]) c = (c << 1) ^ 8'h07;
            else             c = c << 1;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic b);
        @(negedge clk);
        spi_mosi = b;
        wait_clk(HALF);
        spi_sck = 1'b1;
        wait_clk(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit push);
        for (int i = n - 1; i >= 0; i--) begin
            if (push) exp_q.push_back(v[i]);
            sck_bit(v[i]);
        end
    endtask

    task automatic cs_set(input logic v);
        @(negedge clk);
        spi_cs_n = v;
        wait_clk(6);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"},  32'(cfg_data),     32'd0);
        check({tag, "_shift"}, 32'(cfg_shift_en), 32'd0);
        check({tag, "_done"},  32'(cfg_done),     32'd0);
        check({tag, "_error"}, 32'(cfg_error),    32'd0);
        check({tag, "_frst"},  32'(fabric_rst),   32'd1);
        check({tag, "_busy"},  32'(busy),         32'd0);
    endtask

    task automatic full_frame(input logic [7:0] cmd, input logic [15:0] p, input logic [7:0] c);
        nstrobe = 0;
        cs_set(1'b0);
        send_bits(32'(cmd), 8, 1'b0);
        send_bits(32'(p), 16, cmd == 8'hA5);
        send_bits(32'(c), 8, 1'b0);
        wait_clk(6);
    endtask

    initial begin
        rst      = 1'b1;
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(6);
        check_reset_vals("reset");
        rst = 1'b0;
        wait_clk(4);
        check_reset_vals("idle");

        // Valid frame 0xBEEF
        full_frame(8'hA5, 16'hBEEF, crc_model(16'hBEEF));
        check("valid_strobes", 32'(nstrobe), 32'd16);
        check("valid_done", 32'(cfg_done), 32'd1);
        check("valid_frst", 32'(fabric_rst), 32'd0);
        check("valid_error", 32'(cfg_error), 32'd0);
        check("valid_busy", 32'(busy), 32'd0);
        cs_set(1'b1);
        check("valid_done_after_cs", 32'(cfg_done), 32'd1);

        // Zero frame; reload check right after the cs fall
        nstrobe = 0;
        cs_set(1'b0);
        check("reload_done", 32'(cfg_done), 32'd0);
        check("reload_frst", 32'(fabric_rst), 32'd1);
        check("reload_busy", 32'(busy), 32'd1);
        send_bits(32'hA5, 8, 1'b0);
        send_bits(32'h0000, 16, 1'b1);
        send_bits(32'h00, 8, 1'b0);
        wait_clk(6);
        check("zero_strobes", 32'(nstrobe), 32'd16);
        check("zero_done", 32'(cfg_done), 32'd1);
        cs_set(1'b1);

        // Bad CRC
        full_frame(8'hA5, 16'hBEEF, crc_model(16'hBEEF) ^ 8'h01);
        check("badcrc_strobes", 32'(nstrobe), 32'd16);
        check("badcrc_error", 32'(cfg_error), 32'd1);
        check("badcrc_done", 32'(cfg_done), 32'd0);
        check("badcrc_frst", 32'(fabric_rst), 32'd1);
        cs_set(1'b1);

        // Bad command: error only after the eighth bit
        nstrobe = 0;
        cs_set(1'b0);
        send_bits(32'h2D, 7, 1'b0);
        wait_clk(4);
        check("badcmd_error_early", 32'(cfg_error), 32'd0);
        check("badcmd_busy_early", 32'(busy), 32'd1);
        send_bits(32'h0, 1, 1'b0);
        wait_clk(4);
        check("badcmd_error", 32'(cfg_error), 32'd1);
        send_bits(32'hFFFF, 16, 1'b0);
        check("badcmd_strobes", 32'(nstrobe), 32'd0);
        cs_set(1'b1);

        // Truncated frame, then a clean reload
        nstrobe = 0;
        cs_set(1'b0);
        send_bits(32'hA5, 8, 1'b0);
        send_bits(32'h5B, 7, 1'b1);
        cs_set(1'b1);
        check("trunc_strobes", 32'(nstrobe), 32'd7);
        check("trunc_error", 32'(cfg_error), 32'd1);
        check("trunc_busy", 32'(busy), 32'd0);
        full_frame(8'hA5, 16'h1234, crc_model(16'h1234));
        check("after_trunc_done", 32'(cfg_done), 32'd1);
        check("after_trunc_error", 32'(cfg_error), 32'd0);
        cs_set(1'b1);

        // Reset mid-load
        nstrobe = 0;
        cs_set(1'b0);
        send_bits(32'hA5, 8, 1'b0);
        send_bits(32'h13, 5, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        send_bits(32'h7FF, 11, 1'b0);
        wait_clk(4);
        check("midrst_strobes", 32'(nstrobe), 32'd5);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(cfg_done), 32'd0);
        cs_set(1'b1);
        full_frame(8'hA5, 16'hC3A1, crc_model(16'hC3A1));
        check("post_rst_done", 32'(cfg_done), 32'd1);
        check("post_rst_strobes", 32'(nstrobe), 32'd16);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
